// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from NUM_REQ requesters
// into a single UART transmitter, with a start pulse and busy handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  per-requester "byte available"
//   req_data   per-requester byte, requester i on [8i+7:8i]
//   req_lock   (UART_ARB_LOCK_EN only) keep the grant on this requester
//   req_ready  one-cycle accept pulse, one-hot or zero
//   tx_data    latched byte for the transmitter
//   tx_start   one-cycle start pulse for the transmitter
//   tx_busy    transmitter busy flag
//   grant_id   index of the current or last granted requester
//   active     high whenever the arbiter is not idle
//
// Optional feature: define UART_ARB_LOCK_EN to add req_lock.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active
);

    localparam int GW = $clog2(NUM_REQ);
    localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [NUM_REQ-1:0] ready_n;
    logic               start_n;
    logic [7:0]         data_n;
    logic [GW-1:0]      gid_n;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      last_n;
    logic [1:0]         quiet;
    logic [1:0]         quiet_n;
    logic               done;

    logic               rr_found;
    logic [GW-1:0]      rr_pick;
    logic [GW-1:0]      rr_idx;
    logic               found;
    logic [GW-1:0]      pick;
    logic [7:0]         pick_data;
    logic               lock_hit;
    logic [GW-1:0]      lock_sel;
    logic               hold_last;

    // Round-robin search upward from last_grant+1, wrapping at NUM_REQ-1.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = last_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (rr_idx == LAST) ? '0 : rr_idx + 1'b1;
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    assign found = lock_hit | rr_found;
    assign pick  = lock_hit ? lock_sel : rr_pick;

    always_comb begin
        pick_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GW'(i)) begin
                pick_data = req_data[8*i +: 8];
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic          lock_on;
    logic          lock_on_n;
    logic [GW-1:0] lock_id;
    logic [GW-1:0] lock_id_n;

    // The lock is captured at acceptance and dropped either by an
    // unlocked byte from the holder or by the holder going idle.
    always_comb begin
        lock_on_n = lock_on;
        lock_id_n = lock_id;
        if (state == IDLE) begin
            if (lock_on && !req_valid[lock_id]) begin
                lock_on_n = 1'b0;
            end
            if (found && !tx_busy) begin
                lock_on_n = req_lock[pick];
                lock_id_n = pick;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_on <= 1'b0;
            lock_id <= '0;
        end else begin
            lock_on <= lock_on_n;
            lock_id <= lock_id_n;
        end
    end

    assign lock_hit  = lock_on & req_valid[lock_id];
    assign lock_sel  = lock_id;
    assign hold_last = lock_on;
`else
    assign lock_hit  = 1'b0;
    assign lock_sel  = '0;
    assign hold_last = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ready_n = '0;
        start_n = 1'b0;
        data_n  = tx_data;
        gid_n   = grant_id;
        last_n  = last_grant;
        quiet_n = quiet;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    ready_n[pick] = 1'b1;
                    data_n        = pick_data;
                    gid_n         = pick;
                    state_n       = LAUNCH;
                end
            end
            LAUNCH: begin
                start_n = 1'b1;
                quiet_n = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never answers must not hang us:
                // four quiet cycles count the byte as sent.
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (quiet == 2'd3) begin
                    done = 1'b1;
                end else begin
                    quiet_n = quiet + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (done) begin
            state_n = IDLE;
            if (!hold_last) begin
                last_n = grant_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            grant_id   <= '0;
            last_grant <= LAST;
            quiet      <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= ready_n;
            tx_start   <= start_n;
            tx_data    <= data_n;
            grant_id   <= gid_n;
            last_grant <= last_n;
            quiet      <= quiet_n;
        end
    end

    assign active = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have the parameter NUM_REQ, default 4, which sets the number of requesters (2..8).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port req_valid, input, NUM_REQ bits: requester i holds a byte.
REQ-005 The block SHALL have the port req_data, input, 8*NUM_REQ bits: the byte of requester i is on bits [8i+7:8i].
REQ-006 The block SHALL have the port req_ready, output, NUM_REQ bits: a one-cycle accept pulse; the byte transfers when valid and ready are both high.
REQ-007 The block SHALL have the port tx_data, output, 8 bits: the latched byte, wired to the transmitter data input.
REQ-008 The block SHALL have the port tx_start, output, 1 bit: a one-cycle start pulse to the transmitter.
REQ-009 The block SHALL have the port tx_busy, input, 1 bit: the transmitter busy flag.
REQ-010 The block SHALL have the port grant_id, output, clog2(NUM_REQ) bits: the index of the current or last granted requester.
REQ-011 The block SHALL have the port active, output, 1 bit: high in every state other than IDLE.

Function
REQ-012 The block SHALL implement four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-013 In IDLE with at least one req_valid high and tx_busy low, the block SHALL grant the first valid requester found by searching upward from last_grant+1 with wrap-around.
- Registered outputs in the following cycle: req_ready[i]=1, tx_data=req_data[i], grant_id=i.
- Next state: LAUNCH.
REQ-014 In IDLE with tx_busy high, the block SHALL grant nothing, even if requests are pending.
REQ-015 req_ready SHALL be one-hot or zero, and SHALL be high for exactly one cycle per granted byte.
REQ-016 In LAUNCH, tx_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT_BUSY.
- Latency: the tx_start cycle immediately follows the req_ready cycle.
REQ-017 In WAIT_BUSY, the block SHALL stay until tx_busy=1 and then move to WAIT_DONE.
- If tx_busy stays 0 for 4 consecutive cycles, the block SHALL return to IDLE and count the byte as sent, which prevents a deadlock.
REQ-018 In WAIT_DONE, on tx_busy=0 the block SHALL update last_grant to grant_id and return to IDLE.
- A new grant is possible on the same edge-following cycle.
REQ-019 tx_data SHALL remain stable from the req_ready cycle until the block returns to IDLE.
REQ-020 Changes to req_valid or req_data while the block is not in IDLE SHALL have no effect.
REQ-021 If a requester drops req_valid before it is granted, the block SHALL skip that requester with no penalty.
REQ-022 Under full load, the block SHALL service requesters in the order i, i+1, ..., wrapping to 0, so no requester waits more than NUM_REQ-1 other bytes.

Reset
REQ-023 While reset is high, the block SHALL hold: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), lock state cleared.
REQ-024 Reset asserted mid-transfer SHALL abort immediately.
- The byte in flight is not retried.
- After reset deasserts, arbitration resumes from requester 0.

Configuration
REQ-025 When the macro UART_ARB_LOCK_EN is defined, the block SHALL add the input req_lock, NUM_REQ bits.
- If req_lock[i] is high at acceptance, the next IDLE grant goes to requester i when req_valid[i] is high, ignoring round-robin order; last_grant does not advance.
- The lock releases when the block accepts a byte with req_lock[i]=0, or when req_valid[i] is low in IDLE.
REQ-026 When UART_ARB_LOCK_EN is not defined, the req_lock port SHALL be absent and the block SHALL use pure round-robin only.

Verification
REQ-027 Single request scenario: after reset, req_valid=4'b0100 with byte 0x5A and a transmitter model that raises busy 1 cycle after start and holds it for 20 cycles.
- Required response: req_ready[2] is a 1-cycle pulse, then tx_start on the next cycle with tx_data=0x5A, grant_id=2, and active low again after busy falls.
REQ-028 Full-load scenario: req_valid=4'b1111 held, bytes 0x10, 0x11, 0x12, 0x13.
- Required response: tx_start sequence carries 0x10, 0x11, 0x12, 0x13, 0x10; exactly one tx_start per busy period.
REQ-029 Busy-held scenario: tx_busy forced to 1 while in IDLE with requests pending.
- Required response: no req_ready and no tx_start; on release, the grant goes to requester 0.
REQ-030 Reset mid-transfer scenario: reset pulsed during WAIT_DONE.
- Required response: all outputs are 0 in the same cycle; the next grant is to requester 0 even if requester 3 was pending.
REQ-031 Missing-busy scenario: the transmitter model never raises busy.
- Required response: the block returns to IDLE 4 cycles after tx_start, and the next requester is granted.
REQ-032 Lock scenario, with UART_ARB_LOCK_EN defined: requester 1 sends 3 bytes with lock=1,1,0 while requester 2 is valid throughout.
- Required response: grant order 1, 1, 1, 2.
